// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a block-fill FSM in front of a pipelined memory.
// Hits return in the lookup cycle; a miss stalls fetch while the whole block is refilled.
module icache_fill_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned INDEX_BITS  = 5,
  parameter int unsigned OFFSET_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              hit,
  output logic              stall,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TagW      = ADDR_W - INDEX_BITS - OFFSET_BITS - 1;
  localparam int unsigned NumBlocks = 1 << INDEX_BITS;
  localparam int unsigned NumWords  = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TagW-1:0]        tag;
  logic                   unused_addr0;

  assign offset       = addr[OFFSET_BITS:1];
  assign index        = addr[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1];
  assign tag          = addr[ADDR_W-1:OFFSET_BITS+INDEX_BITS+1];
  assign unused_addr0 = addr[0];

  logic [DATA_W-1:0]      data_mem [NumBlocks*NumWords];
  logic [TagW-1:0]        tag_mem  [NumBlocks];
  logic [NumBlocks-1:0]   valid_q;

  state_e                 state_q;
  logic [INDEX_BITS-1:0]  idx_q;
  logic [TagW-1:0]        fill_tag_q;
  logic [OFFSET_BITS-1:0] issue_cnt_q;
  logic [OFFSET_BITS-1:0] recv_cnt_q;
  logic                   flush_pend_q;
  logic                   mem_en_q;
  logic [ADDR_W-1:0]      mem_addr_q;

  logic lookup_hit;
  logic capture;
  logic last_word;

  assign lookup_hit = (state_q == StIdle) & valid_q[index] & (tag_mem[index] == tag);
  assign hit        = req & lookup_hit;
  assign stall      = req & ~hit;
  assign instr      = hit ? data_mem[{index, offset}] : '0;

  // Returns are only accepted while a fill is outstanding; stragglers in IDLE/DONE are dropped.
  assign capture   = mem_rvalid & ((state_q == StReq) | (state_q == StWait));
  assign last_word = capture & (recv_cnt_q == OFFSET_BITS'(NumWords - 1));

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

  // Data and tag storage are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      data_mem[{idx_q, recv_cnt_q}] <= mem_rdata;
    end
    if (last_word) begin
      tag_mem[idx_q] <= fill_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      idx_q        <= '0;
      fill_tag_q   <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      if (capture) begin
        recv_cnt_q <= recv_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            valid_q <= '0;
          end
          if (req && !lookup_hit) begin
            valid_q[index] <= 1'b0;
            idx_q          <= index;
            fill_tag_q     <= tag;
            issue_cnt_q    <= '0;
            recv_cnt_q     <= '0;
            mem_en_q       <= 1'b1;
            mem_addr_q     <= {tag, index, {(OFFSET_BITS + 1){1'b0}}};
            state_q        <= StReq;
          end
        end
        StReq: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          issue_cnt_q <= issue_cnt_q + 1'b1;
          if (issue_cnt_q == OFFSET_BITS'(NumWords - 1)) begin
            mem_en_q <= 1'b0;
            state_q  <= StWait;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(2);
          end
          // A fast memory can finish the block before the last issue cycle.
          if (last_word) begin
            valid_q[idx_q] <= 1'b1;
            mem_en_q       <= 1'b0;
            state_q        <= StDone;
          end
        end
        StWait: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (last_word) begin
            valid_q[idx_q] <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          if (flush_pend_q || flush) begin
            valid_q <= '0;
          end
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule
